// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM state encoding,
// bus field widths and the request legality check.
package sram_arb_pkg;

  localparam int INST_W = 8;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 24;

  localparam logic [ADDR_W-1:0] DEF_MAX_ADDRESS = 24'h01FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } arb_state_e;

  // Last byte touched is addr+len-1, kept one bit wider so a wrap past 2^24 still reads as out of range.
  function automatic logic req_illegal(input logic [ADDR_W-1:0] addr,
                                       input logic [LEN_W-1:0]  len,
                                       input logic [ADDR_W-1:0] max_addr);
    logic [ADDR_W:0] end_addr;
    end_addr = {1'b0, addr} + {1'b0, len} - {{ADDR_W{1'b0}}, 1'b1};
    return (len == '0) || (end_addr > {1'b0, max_addr});
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the arbiter. The master modport is
// the arbiter's view; the slave modport is the view of the surrounding logic.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import sram_arb_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][INST_W-1:0] req_inst;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]             req_write_in;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic [NUM_REQ-1:0]             err;
  logic                           rsp_so;
  logic [NUM_REQ-1:0]             rsp_output_valid;
  logic [NUM_REQ-1:0]             rsp_input_valid;

  logic [INST_W-1:0]              sram_inst;
  logic [ADDR_W-1:0]              sram_address;
  logic [LEN_W-1:0]               sram_length;
  logic                           sram_start;
  logic                           sram_write_in;
  logic                           sram_so;
  logic                           sram_output_valid;
  logic                           sram_input_valid;
  logic                           sram_done;

  modport master (
    input  req, req_inst, req_addr, req_len, req_write_in,
    output grant, done, err, rsp_so, rsp_output_valid, rsp_input_valid,
    output sram_inst, sram_address, sram_length, sram_start, sram_write_in,
    input  sram_so, sram_output_valid, sram_input_valid, sram_done
  );

  modport slave (
    output req, req_inst, req_addr, req_len, req_write_in,
    input  grant, done, err, rsp_so, rsp_output_valid, rsp_input_valid,
    input  sram_inst, sram_address, sram_length, sram_start, sram_write_in,
    output sram_so, sram_output_valid, sram_input_valid, sram_done
  );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: scans from last_grant+1 upward, wrapping,
// and returns the first set request as a one-hot winner.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int LG_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LG_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_winner
);

  always_comb begin
    logic w_found;
    int   w_idx;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = (int'(i_last_grant) + i) % NUM_REQ;
      if (!w_found && i_req[w_idx[LG_W-1:0]]) begin
        o_winner[w_idx[LG_W-1:0]] = 1'b1;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM driver channel among NUM_REQ requesters, round-robin.
// Optional WAIT watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | channel free; any req moves to arbitration
// S_ARB    | pick winner, latch its command, check legality
// S_ISSUE  | one-cycle sram_start with the latched command
// S_WAIT   | owner connected to the SRAM until sram_done (or watchdog)
// S_FINISH | done (and err if rejected/aborted) to the owner; record owner
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int                NUM_REQ     = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDRESS = DEF_MAX_ADDRESS,
  parameter int                TIMEOUT     = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_port_arbiter_if.master  bus
);

  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  arb_state_e         w_next;
  logic [LG_W-1:0]    r_owner;
  logic [LG_W-1:0]    r_last_grant;
  logic [INST_W-1:0]  r_inst;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic               r_illegal;
  logic               r_timed_out;
  logic [NUM_REQ-1:0] w_winner;
  logic [LG_W-1:0]    w_win_idx;
  logic               w_illegal;
  logic               w_timeout_hit;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_busy;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .LG_W    (LG_W)
  ) u_picker (
    .i_req        (bus.req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_win_idx = LG_W'(i);
    end
  end

  assign w_illegal = req_illegal(bus.req_addr[w_win_idx], bus.req_len[w_win_idx], MAX_ADDRESS);

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;

  // Count reaches TIMEOUT on the same edge that moves the FSM to FINISH.
  assign w_timeout_hit = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_wait_cnt  <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_timeout_hit && !bus.sram_done) r_timed_out <= 1'b1;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign r_timed_out   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|bus.req) w_next = S_ARB;
      // Request may have dropped since IDLE; with no winner just go back.
      S_ARB: begin
        if (!(|w_winner))   w_next = S_IDLE;
        else if (w_illegal) w_next = S_FINISH;
        else                w_next = S_ISSUE;
      end
      S_ISSUE:  w_next = S_WAIT;
      S_WAIT:   if (bus.sram_done || w_timeout_hit) w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= '0;
      r_last_grant <= LG_W'(NUM_REQ - 1);
      r_inst       <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_illegal    <= 1'b0;
    end else begin
      if (r_state == S_ARB && (|w_winner)) begin
        r_owner   <= w_win_idx;
        r_inst    <= bus.req_inst[w_win_idx];
        r_addr    <= bus.req_addr[w_win_idx];
        r_len     <= bus.req_len[w_win_idx];
        r_illegal <= w_illegal;
      end
      if (r_state == S_FINISH) r_last_grant <= r_owner;
    end
  end

  assign w_owner_oh = NUM_REQ'(1) << r_owner;
  assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_FINISH);

  assign bus.grant            = w_busy ? w_owner_oh : '0;
  assign bus.done             = (r_state == S_FINISH) ? w_owner_oh : '0;
  assign bus.err              = (r_state == S_FINISH && (r_illegal || r_timed_out)) ? w_owner_oh : '0;
  assign bus.rsp_so           = bus.sram_so;
  assign bus.rsp_output_valid = (r_state == S_WAIT && bus.sram_output_valid) ? w_owner_oh : '0;
  assign bus.rsp_input_valid  = (r_state == S_WAIT && bus.sram_input_valid) ? w_owner_oh : '0;

  assign bus.sram_inst     = r_inst;
  assign bus.sram_address  = r_addr;
  assign bus.sram_length   = r_len;
  assign bus.sram_start    = (r_state == S_ISSUE);
  assign bus.sram_write_in = (r_state == S_WAIT) && bus.req_write_in[r_owner];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (two requesters, TIMEOUT=16); the
// watchdog case follows SRAM_ARB_TIMEOUT_EN.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_REQ(2)) bus ();

  sram_port_arbiter #(
    .NUM_REQ     (2),
    .MAX_ADDRESS (24'h01FFFF),
    .TIMEOUT     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [7:0]  cap_inst;
  logic [23:0] cap_addr;
  logic [23:0] cap_len;

  always @(negedge clk) begin
    if (bus.sram_start) begin
      cap_inst <= bus.sram_inst;
      cap_addr <= bus.sram_address;
      cap_len  <= bus.sram_length;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [7:0] inst, input logic [23:0] a, input logic [23:0] l);
    bus.req_inst[r] = inst;
    bus.req_addr[r] = a;
    bus.req_len[r]  = l;
  endtask

  // Plays the SRAM driver: answers sram_done dly cycles after sram_start
  // (dly=0 means never) and returns when a done pulse is seen or 60 cycles pass.
  task automatic serve(input int dly, output logic [1:0] g, output logic [1:0] d,
                       output logic [1:0] e, output int ns, output int lat, output int gbad);
    int cnt;
    cnt = -1; g = '0; d = '0; e = '0; ns = 0; lat = -1; gbad = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      bus.sram_done = 1'b0;
      if (bus.sram_start) begin
        ns++;
        g   = bus.grant;
        cnt = (dly > 0) ? dly : -1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.sram_done = 1'b1;
      end
      if (ns > 0 && bus.grant !== g) gbad++;
      if (bus.done !== 2'b00) begin
        d   = bus.done;
        e   = bus.err;
        if (g == 2'b00) g = bus.grant;
        lat = c;
        break;
      end
    end
  endtask

  logic [1:0] g, d, e;
  int ns, lat, gbad;

  initial begin
    bus.req = '0; bus.req_inst = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_write_in = '0;
    bus.sram_so = 1'b0; bus.sram_output_valid = 1'b0; bus.sram_input_valid = 1'b0; bus.sram_done = 1'b0;

    // reset values
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_start", bus.sram_start, 0);
    chk("rst_wr", bus.sram_write_in, 0);
    chk("rst_ovld", bus.rsp_output_valid, 0);
    chk("rst_ivld", bus.rsp_input_valid, 0);
    chk("rst_inst", bus.sram_inst, 0);
    chk("rst_addr", bus.sram_address, 0);
    chk("rst_len", bus.sram_length, 0);
    rst_n = 1'b1;
    bus.sram_done = 1'b1;
    tick();
    bus.sram_done = 1'b0;
    chk("idle_done_ignored", bus.done, 0);

    // basic legal operation, sram_done 10 cycles after start
    set_req(0, 8'h03, 24'h000100, 24'd4);
    bus.req = 2'b01;
    serve(10, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
    chk("t1_start_pulses", ns, 1);
    chk("t1_grant", g, 2'b01);
    chk("t1_grant_held", gbad, 0);
    chk("t1_done", d, 2'b01);
    chk("t1_err", e, 2'b00);
    chk("t1_latency", lat, 13);
    chk("t1_inst", cap_inst, 8'h03);
    chk("t1_addr", cap_addr, 24'h000100);
    chk("t1_len", cap_len, 24'd4);
    tick();
    chk("t1_grant_cleared", bus.grant, 0);

    // owner-only routing, req drop after ARB does not abort
    set_req(1, 8'h02, 24'h000200, 24'd8);
    bus.req = 2'b10;
    tick();
    tick();
    chk("t2_start", bus.sram_start, 1);
    chk("t2_grant", bus.grant, 2'b10);
    tick();
    bus.req = 2'b00;
    bus.req_write_in = 2'b10; bus.sram_output_valid = 1'b1; bus.sram_input_valid = 1'b1;
    #1;
    chk("t2_wr_owner", bus.sram_write_in, 1);
    chk("t2_ovld", bus.rsp_output_valid, 2'b10);
    chk("t2_ivld", bus.rsp_input_valid, 2'b10);
    chk("t2_addr_hold", bus.sram_address, 24'h000200);
    bus.req_write_in = 2'b01;
    #1;
    chk("t2_wr_nonowner", bus.sram_write_in, 0);
    bus.req_write_in = 2'b00; bus.sram_output_valid = 1'b0; bus.sram_input_valid = 1'b0;
    bus.sram_done = 1'b1;
    tick();
    bus.sram_done = 1'b0;
    chk("t2_done", bus.done, 2'b10);
    chk("t2_err", bus.err, 2'b00);
    tick();
    chk("t2_idle_grant", bus.grant, 0);

    // round robin with both requesting after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 8'h03, 24'h000010, 24'd2);
    set_req(1, 8'h03, 24'h000020, 24'd2);
    bus.req = 2'b11;
    serve(3, g, d, e, ns, lat, gbad);
    chk("rr_round1", g, 2'b01);
    serve(3, g, d, e, ns, lat, gbad);
    chk("rr_round2", g, 2'b10);
    chk("rr_round2_lat", lat, 7);
    serve(3, g, d, e, ns, lat, gbad);
    chk("rr_round3", g, 2'b01);
    bus.req = 2'b01;
    serve(3, g, d, e, ns, lat, gbad);
    chk("single_regrant_a", g, 2'b01);
    serve(3, g, d, e, ns, lat, gbad);
    chk("single_regrant_b", g, 2'b01);
    bus.req = 2'b00;
    tick();

    // end address one past MAX_ADDRESS is rejected
    set_req(0, 8'h02, 24'h01FFFF, 24'd2);
    bus.req = 2'b01;
    serve(3, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
    chk("oob_no_start", ns, 0);
    chk("oob_done", d, 2'b01);
    chk("oob_err", e, 2'b01);
    chk("oob_latency", lat, 2);
    tick();
    set_req(0, 8'h02, 24'h01FFFF, 24'd1);
    bus.req = 2'b01;
    serve(3, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
    chk("edge_start", ns, 1);
    chk("edge_done", d, 2'b01);
    chk("edge_err", e, 2'b00);
    chk("edge_len", cap_len, 24'd1);
    tick();

    // zero length is rejected
    set_req(0, 8'h03, 24'h000000, 24'd0);
    bus.req = 2'b01;
    serve(3, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
    chk("len0_no_start", ns, 0);
    chk("len0_err", e, 2'b01);
    tick();

    // reset during WAIT abandons the operation
    set_req(1, 8'h0B, 24'h000300, 24'd16);
    bus.req = 2'b10;
    tick(); tick(); tick();
    chk("mid_wait_grant", bus.grant, 2'b10);
    rst_n = 1'b0;
    bus.req = 2'b00;
    tick();
    chk("mrst_grant", bus.grant, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_addr", bus.sram_address, 0);
    chk("mrst_inst", bus.sram_inst, 0);
    rst_n = 1'b1;
    bus.sram_done = 1'b1;
    tick();
    bus.sram_done = 1'b0;
    chk("mrst_late_done", bus.done, 0);
    set_req(0, 8'h03, 24'h000040, 24'd4);
    set_req(1, 8'h03, 24'h000050, 24'd4);
    bus.req = 2'b11;
    serve(2, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
    chk("mrst_next_owner", g, 2'b01);
    tick();

    // no sram_done: watchdog fires, or grant is held
    set_req(0, 8'h03, 24'h000080, 24'd4);
    bus.req = 2'b01;
    serve(0, g, d, e, ns, lat, gbad);
    bus.req = 2'b00;
`ifdef SRAM_ARB_TIMEOUT_EN
    chk("to_done", d, 2'b01);
    chk("to_err", e, 2'b01);
    chk("to_latency", lat, 19);
    tick();
`else
    chk("hold_no_done", lat, -1);
    chk("hold_grant", bus.grant, 2'b01);
    bus.sram_done = 1'b1;
    tick();
    bus.sram_done = 1'b0;
    chk("hold_late_done", bus.done, 2'b01);
    chk("hold_late_err", bus.err, 2'b00);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2: number of requesters sharing one SRAM channel.
REQ-002 The block SHALL have parameter MAX_ADDRESS, default 'h1FFFF: highest legal SRAM byte address.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535: watchdog limit in cycles (used only under REQ-024).
REQ-004 The block SHALL have a single clock, clk, input, 1 bit; all logic clocks on its rising edge.
REQ-005 The block SHALL have reset rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 The block SHALL have the following requester-side ports:
- req: input, NUM_REQ bits; per-requester access request, level.
- req_inst: input, NUM_REQ x 8 bits; SRAM opcode.
- req_addr: input, NUM_REQ x 24 bits; start address.
- req_len: input, NUM_REQ x 24 bits; byte count.
- req_write_in: input, NUM_REQ bits; serial write data.
- grant: output, NUM_REQ bits; one-hot owner of the channel.
- done: output, NUM_REQ bits; one-cycle completion pulse.
- err: output, NUM_REQ bits; one-cycle pulse with done, meaning rejected or aborted.
- rsp_so: output, 1 bit; SRAM serial-out, broadcast to all requesters.
- rsp_output_valid: output, NUM_REQ bits; SRAM output_valid routed to the owner only.
- rsp_input_valid: output, NUM_REQ bits; SRAM input_valid routed to the owner only.
REQ-007 The block SHALL have the following SRAM-side ports:
- sram_inst: output, 8 bits.
- sram_address: output, 24 bits.
- sram_length: output, 24 bits.
- sram_start: output, 1 bit; one-cycle launch pulse.
- sram_write_in: output, 1 bit.
- sram_so: input, 1 bit.
- sram_output_valid: input, 1 bit.
- sram_input_valid: input, 1 bit.
- sram_done: input, 1 bit; one-cycle completion pulse from the SRAM driver.

Function
REQ-008 The FSM SHALL have states IDLE, ARB, ISSUE, WAIT and FINISH.
REQ-009 In IDLE with any req bit set, the FSM SHALL go to ARB on the next cycle.
REQ-010 In ARB the block SHALL select the winner round-robin: the search starts at last_grant+1, wraps modulo NUM_REQ, and the first set req bit wins.
REQ-011 In ARB the block SHALL latch the winner's inst, addr and len into registers and drive its grant bit high from the next cycle.
REQ-012 Validity check: end = addr + len - 1, computed at 25 bits; the request is illegal if len == 0 or end > MAX_ADDRESS.
REQ-013 If the request is illegal, the block SHALL skip ISSUE and WAIT, go to FINISH, and pulse err with done.
REQ-014 In ISSUE the block SHALL assert sram_start for exactly one cycle with the latched inst, address and length, then go to WAIT.
REQ-015 In WAIT:
- sram_write_in SHALL equal the owner's req_write_in.
- rsp_output_valid and rsp_input_valid SHALL be nonzero only in the owner's bit.
- The FSM SHALL leave on sram_done.
REQ-016 In FINISH the block SHALL:
- pulse done[owner] for one cycle;
- clear grant;
- update last_grant to the owner;
- return to IDLE.
REQ-017 Minimum latency from req rising (in IDLE) to done SHALL be 4 cycles plus the SRAM execution time; there is a mandatory one-cycle IDLE gap between grants.
REQ-018 A req that drops after ARB SHALL NOT abort the operation: it completes and done still pulses.
REQ-019 New req edges during ARB/ISSUE/WAIT/FINISH SHALL wait; there is no preemption.
REQ-020 sram_done outside WAIT SHALL be ignored; sram_inst, sram_address and sram_length SHALL hold their latched values from ISSUE through WAIT.
REQ-021 With a single requester holding req continuously, the block SHALL regrant the same requester every round.

Reset
REQ-022 On rst_n = 0 at a clock edge:
- state SHALL go to IDLE and last_grant to NUM_REQ-1, so requester 0 has first priority.
- grant, done, err, sram_start, sram_write_in, rsp_output_valid and rsp_input_valid SHALL be 0.
- sram_inst, sram_address and sram_length SHALL be 0.
REQ-023 Reset asserted mid-WAIT SHALL abandon the operation silently: no done pulse, and a subsequent sram_done is ignored.

Configuration
REQ-024 With macro SRAM_ARB_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to WAIT and increment each WAIT cycle;
- on reaching TIMEOUT, force FINISH with err=1 and done=1 for the owner.
Without the macro, there SHALL be no counter and WAIT SHALL be unbounded.

Structure
REQ-025 Package sram_arb_pkg SHALL hold the state enum, the default MAX_ADDRESS constant and the opcode/address/length width constants.
REQ-026 Round-robin selection SHALL be a sub-module, rr_priority_picker: inputs req and last_grant, output a one-hot winner, purely combinational.

Verification
REQ-027 Test: reset, then req=2'b01 with inst=8'h03, addr=24'h000100, len=24'd4, and sram_done 10 cycles after sram_start. Required: sram_start a single pulse; done[0] pulses and err=0; grant=2'b01 throughout.
REQ-028 Test: req=2'b11 held for three rounds. Required: grants alternate 01, 10, 01 after reset.
REQ-029 Test: addr=24'h1FFFF with len=2. Required: no sram_start, done and err pulse; len=1 at the same addr is accepted.
REQ-030 Test: len=0. Required: err pulse, no sram_start.
REQ-031 Test: rst_n low mid-WAIT, then sram_done. Required: no done; all outputs 0; next grant goes to requester 0.
REQ-032 Test: with SRAM_ARB_TIMEOUT_EN, TIMEOUT=16 and no sram_done. Required: done and err pulse 16 cycles after WAIT entry; without the macro, grant is held indefinitely.
